// File: rtl/dcache_pkg.sv
// Shared types and address-field width helpers for the write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } state_e;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_words);
    return addr_w - 2 - idx_w(sets) - off_w(line_words);
  endfunction

  // Port widths cannot be zero, so a one-word line still carries a 1-bit offset.
  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: valid bits (reset), tag and data arrays (not reset),
// combinational read at the request index, byte-enabled word writes.
module dcache_way
  import dcache_pkg::*;
#(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 24
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear_all,
  input  logic [idx_w(SETS)-1:0]             idx,
  input  logic [max1(off_w(LINE_WORDS))-1:0] rd_word,
  output logic                               rd_valid,
  output logic [TAG_W-1:0]                   rd_tag,
  output logic [31:0]                        rd_data,
  input  logic                               inv,
  input  logic                               fill,
  input  logic [TAG_W-1:0]                   fill_tag,
  input  logic                               wr_en,
  input  logic [max1(off_w(LINE_WORDS))-1:0] wr_word,
  input  logic [3:0]                         wr_be,
  input  logic [31:0]                        wr_data
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][LINE_WORDS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (inv) begin
      valid_q[idx] <= 1'b0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[idx] <= fill_tag;
    end
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) begin
          data_q[idx][wr_word][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_data  = data_q[idx][rd_word];

endmodule

// File: rtl/dcache_ctrl.sv
// Set-associative write-through, no-write-allocate data cache controller.
// state   | meaning
// IDLE    | serve load hits, accept flush, dispatch misses and stores
// RD_REQ  | line read request held until mem_ready_i
// RD_DATA | collecting LINE_WORDS refill beats into the victim way
// WR      | single-word write request held until mem_ready_i
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  input  logic [3:0]        cpu_be_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       hit_count_o,
  output logic [31:0]       miss_count_o
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int OFF_B = max1(OFF_W);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_WORDS);

  logic [ADDR_W-1:0] word_addr;
  logic [OFF_B-1:0]  cpu_off;
  logic [IDX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]  cpu_tag;

  assign word_addr = cpu_addr_i >> 2;
  assign cpu_off   = OFF_B'(word_addr & ADDR_W'(LINE_WORDS - 1));
  assign cpu_idx   = IDX_W'(word_addr >> OFF_W);
  assign cpu_tag   = TAG_W'(cpu_addr_i >> (2 + OFF_W + IDX_W));

  state_e            state_q, state_d;
  logic [OFF_B-1:0]  beat_q, beat_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              victim_q, victim_d, st_hit_q, st_hit_d;
  logic [SETS-1:0]   lru_q;
  logic [31:0]       hit_cnt_q, miss_cnt_q;

  logic [WAYS-1:0]   way_valid, hit_way, way_inv, way_fill, way_wr_en;
  logic [WAYS-1:0]   victim_oh, miss_oh;
  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [31:0]       way_data [WAYS];
  logic [OFF_B-1:0]  wr_word;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data;
  logic              clear_all, hit, hit_sel, victim;
  logic              hit_inc, miss_inc, lru_we, lru_val;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .clear_all (clear_all),
      .idx       (cpu_idx),
      .rd_word   (cpu_off),
      .rd_valid  (way_valid[w]),
      .rd_tag    (way_tag[w]),
      .rd_data   (way_data[w]),
      .inv       (way_inv[w]),
      .fill      (way_fill[w]),
      .fill_tag  (cpu_tag),
      .wr_en     (way_wr_en[w]),
      .wr_word   (wr_word),
      .wr_be     (wr_be),
      .wr_data   (wr_data)
    );
    assign hit_way[w] = way_valid[w] && (way_tag[w] == cpu_tag);
  end

  assign hit = |hit_way;

  always_comb begin
    hit_sel     = 1'b0;
    cpu_rdata_o = way_data[0];
    for (int w = 0; w < WAYS; w++) begin
      if (hit_way[w]) begin
        hit_sel     = (w != 0);
        cpu_rdata_o = way_data[w];
      end
    end
  end

  // Lowest invalid way first, otherwise the LRU way of the set.
  always_comb begin
    victim = 1'b0;
    if (WAYS > 1 && way_valid[0]) begin
      victim = way_valid[WAYS-1] ? lru_q[cpu_idx] : 1'b1;
    end
    for (int w = 0; w < WAYS; w++) begin
      victim_oh[w] = ((w != 0) == victim_q);
      miss_oh[w]   = ((w != 0) == victim);
    end
  end

  // A store is released in the cycle its write is accepted, so it is not
  // replayed from IDLE; a flush held during that cycle waits for IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      cpu_stall_o = flush_i | (cpu_req_i & (cpu_we_i | ~hit));
    end else begin
      cpu_stall_o = ~((state_q == WR) && mem_ready_i);
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    victim_d    = victim_q;
    st_hit_d    = st_hit_q;
    way_inv     = '0;
    way_fill    = '0;
    way_wr_en   = '0;
    wr_word     = cpu_off;
    wr_be       = cpu_be_i;
    wr_data     = cpu_wdata_i;
    clear_all   = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    lru_we      = 1'b0;
    lru_val     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          clear_all = 1'b1;
        end else if (cpu_req_i && cpu_we_i) begin
          state_d     = WR;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = cpu_addr_i & ~ADDR_W'(3);
          mem_wdata_d = cpu_wdata_i;
          mem_be_d    = cpu_be_i;
          st_hit_d    = hit;
          way_wr_en   = hit_way;
        end else if (cpu_req_i && hit) begin
          hit_inc = 1'b1;
          lru_we  = (WAYS > 1);
          lru_val = ~hit_sel;
        end else if (cpu_req_i) begin
          state_d     = RD_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = cpu_addr_i & ~ADDR_W'(LINE_WORDS * 4 - 1);
          mem_wdata_d = '0;
          mem_be_d    = '0;
          victim_d    = victim;
          way_inv     = miss_oh;
        end
      end
      RD_REQ: begin
        if (mem_ready_i) begin
          state_d   = RD_DATA;
          mem_req_d = 1'b0;
          beat_d    = '0;
        end
      end
      RD_DATA: begin
        if (mem_rvalid_i) begin
          way_wr_en = victim_oh;
          wr_word   = beat_q;
          wr_be     = 4'hF;
          wr_data   = mem_rdata_i;
          beat_d    = beat_q + OFF_B'(1);
          if (beat_q == OFF_B'(LINE_WORDS - 1)) begin
            way_fill = victim_oh;
            lru_we   = (WAYS > 1);
            lru_val  = ~victim_q;
            miss_inc = 1'b1;
            beat_d   = '0;
            state_d  = IDLE;
          end
        end
      end
      WR: begin
        if (mem_ready_i) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          hit_inc   = st_hit_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      victim_q    <= 1'b0;
      st_hit_q    <= 1'b0;
      lru_q       <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      victim_q    <= victim_d;
      st_hit_q    <= st_hit_d;
      if (clear_all) begin
        lru_q <= '0;
      end else if (lru_we) begin
        lru_q[cpu_idx] <= lru_val;
      end
      if (hit_inc && hit_cnt_q != '1) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_inc && miss_cnt_q != '1) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_be_o     = mem_be_q;
  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed loads/stores/flush/reset against a
// simple word memory responder with configurable request wait.
module tb_dcache_ctrl;

  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_i, cpu_we_i, flush_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
  logic [3:0]  cpu_be_i;
  logic        cpu_stall_o;
  logic        mem_req_o, mem_we_o, mem_ready_i, mem_rvalid_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;
  logic [31:0] hit_count_o, miss_count_o;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_be_i     (cpu_be_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_stall_o  (cpu_stall_o),
    .flush_i      (flush_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .hit_count_o  (hit_count_o),
    .miss_count_o (miss_count_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: ready after mem_wait cycles, refill beats follow acceptance.
  logic [31:0] mem [1024];
  logic        mem_init_done = 1'b0;
  int          mem_wait   = 0;
  int          req_age    = 0;
  int          beats_left = 0;
  logic [31:0] beat_addr  = '0;

  assign mem_ready_i  = mem_req_o && (req_age >= mem_wait);
  assign mem_rvalid_i = (beats_left > 0);
  assign mem_rdata_i  = mem[beat_addr[11:2]];

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | i;
      mem[64]       <= 32'hDEAD_BEEF;
      mem_init_done <= 1'b1;
    end else begin
      req_age <= (mem_req_o && !mem_ready_i) ? req_age + 1 : 0;
      if (mem_req_o && mem_ready_i && !mem_we_o) begin
        beats_left <= LW;
        beat_addr  <= mem_addr_o;
      end else if (beats_left > 0) begin
        beats_left <= beats_left - 1;
        beat_addr  <= beat_addr + 32'd4;
      end
      if (mem_req_o && mem_ready_i && mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_o[b]) mem[mem_addr_o[11:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic [31:0] exp_load_q [$];
  wr_t         exp_wr_q   [$];
  wr_t         mon_wr;

  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_req_i && !cpu_we_i && !cpu_stall_o) begin
        if (exp_load_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL load_unexpected: got data %h with no expected load", cpu_rdata_o);
        end else begin
          check("load_data", cpu_rdata_o, exp_load_q.pop_front());
        end
      end
      if (mem_req_o && mem_we_o && mem_ready_i) begin
        if (exp_wr_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL mem_wr_unexpected: got addr %h with no expected write", mem_addr_o);
        end else begin
          mon_wr = exp_wr_q.pop_front();
          check("mem_wr_addr", mem_addr_o, mon_wr.addr);
          check("mem_wr_data", mem_wdata_o, mon_wr.data);
          check("mem_wr_be", {28'd0, mem_be_o}, {28'd0, mon_wr.be});
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic fl, output int stalls);
    bit done = 0;
    @(posedge clk); #1;
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr;
    cpu_wdata_i = wdata; cpu_be_i = be; flush_i = fl;
    stalls = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (!cpu_stall_o) begin
        done = 1;
        break;
      end
      stalls++;
      @(posedge clk); #1;
      flush_i = 1'b0;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL req_timeout: addr %h still stalled after 64 cycles", addr);
    end
    @(posedge clk); #1;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic load(input string name, input logic [31:0] addr, input logic [31:0] exp_data,
                      input int exp_stalls, input logic fl);
    int st;
    exp_load_q.push_back(exp_data);
    do_req(1'b0, addr, 32'd0, 4'd0, fl, st);
    check({name, "_stalls"}, st, exp_stalls);
  endtask

  task automatic store(input string name, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input int exp_stalls);
    int st;
    exp_wr_q.push_back('{addr, data, be});
    do_req(1'b1, addr, data, be, 1'b0, st);
    check({name, "_stalls"}, st, exp_stalls);
  endtask

  task automatic check_counts(input string name, input logic [31:0] hits, input logic [31:0] misses);
    check({name, "_hits"}, hit_count_o, hits);
    check({name, "_misses"}, miss_count_o, misses);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1'b1;
    cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0; cpu_be_i = '0; flush_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_stall", {31'd0, cpu_stall_o}, 32'd0);
    check_counts("rst", 0, 0);

    load("miss_100", 32'h100, 32'hDEAD_BEEF, 6, 1'b0);
    check_counts("after_miss_100", 1, 1);
    load("hit_104", 32'h104, 32'hA000_0041, 0, 1'b0);
    check_counts("after_hit_104", 2, 1);

    store("st_hit_100", 32'h100, 32'h0000_00AA, 4'b0001, 1);
    check_counts("after_st_100", 3, 1);
    load("hit_100_merged", 32'h100, 32'hDEAD_BEAA, 0, 1'b0);

    mem_wait = 2;
    store("st_hit_108_wait", 32'h108, 32'h5500_0000, 4'b1000, 3);
    load("hit_108_merged", 32'h108, 32'h5500_0042, 0, 1'b0);
    mem_wait = 0;
    store("st_miss_404", 32'h404, 32'h1234_5678, 4'b1111, 1);
    check_counts("after_st_miss", 6, 1);
    load("miss_404_no_alloc", 32'h404, 32'h1234_5678, 6, 1'b0);
    check_counts("after_miss_404", 7, 2);

    mem_wait = 1;
    load("flush_then_miss_104", 32'h104, 32'hA000_0041, 8, 1'b1);
    check_counts("after_flush", 8, 3);
    mem_wait = 0;

    load("ev_000", 32'h000, 32'hA000_0000, 6, 1'b0);
    load("ev_100", 32'h100, 32'hDEAD_BEAA, 0, 1'b0);
    load("ev_000b", 32'h000, 32'hA000_0000, 0, 1'b0);
    load("ev_200", 32'h200, 32'hA000_0080, 6, 1'b0);
    load("ev_000_kept", 32'h000, 32'hA000_0000, 0, 1'b0);
    load("ev_100_evicted", 32'h100, 32'hDEAD_BEAA, 6, 1'b0);
    check_counts("after_evict", 14, 6);

    @(posedge clk); #1;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h300;
    found = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_rvalid_i && beats_left == LW - 2) begin
        found = 1;
        break;
      end
    end
    check("rst_mid_refill_beat2_seen", {31'd0, found}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("midrst_mem_we", {31'd0, mem_we_o}, 32'd0);
    check("midrst_mem_addr", mem_addr_o, 32'd0);
    check("midrst_mem_wdata", mem_wdata_o, 32'd0);
    check_counts("midrst", 0, 0);
    cpu_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    load("reissue_300", 32'h300, 32'hA000_00C0, 6, 1'b0);
    check_counts("after_reissue", 1, 1);

    repeat (2) @(posedge clk);
    check("load_queue_drained", exp_load_q.size(), 0);
    check("wr_queue_drained", exp_wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
